// File: rtl/multicycle_main_control.sv
// Multicycle main control FSM for the LEGv8-subset datapath: sequences each
// instruction, drives ALUop and datapath strobes, counts retired instructions.
module multicycle_main_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [10:0]      opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [1:0]       ALUop,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             PCSource,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             Reg2Loc,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_START, S_FETCH, S_DECODE, S_REX, S_RWB, S_MADDR,
    S_MRD, S_MWB, S_MWR, S_CBZ, S_BR, S_ILL
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_instr_count;

  logic w_is_rtype, w_is_ldur, w_is_stur, w_is_cbz, w_is_b;

  assign w_is_rtype = (opcode == 11'b10001011000) || (opcode == 11'b11001011000) ||
                      (opcode == 11'b10001010000) || (opcode == 11'b10101010000);
  assign w_is_ldur  = (opcode == 11'b11111000010);
  assign w_is_stur  = (opcode == 11'b11111000000);
  assign w_is_cbz   = (opcode[10:3] == 8'b10110100);
  assign w_is_b     = (opcode[10:5] == 6'b000101);

  // zero is consumed by the datapath via PCWriteCond; the FSM never branches on it
  logic w_unused_zero;
  assign w_unused_zero = zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_START;
      r_instr_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (instr_done) r_instr_count <= r_instr_count + 1'b1;
    end
  end

  assign instr_count = r_instr_count;

  always_comb begin
    w_state_next = r_state;
    ALUop        = 2'b00;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    PCSource     = 1'b0;
    PCWrite      = 1'b0;
    PCWriteCond  = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    MemtoReg     = 1'b0;
    RegWrite     = 1'b0;
    instr_done   = 1'b0;
    illegal      = 1'b0;
    // START doubles as the reset state, so every output stays low there
    Reg2Loc      = (r_state != S_START) && (w_is_stur || w_is_cbz);

    case (r_state)
      S_START: w_state_next = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) w_state_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        if (w_is_rtype)                  w_state_next = S_REX;
        else if (w_is_ldur || w_is_stur) w_state_next = S_MADDR;
        else if (w_is_cbz)               w_state_next = S_CBZ;
        else if (w_is_b)                 w_state_next = S_BR;
        else                             w_state_next = S_ILL;
      end
      S_REX: begin
        ALUSrcA      = 1'b1;
        ALUop        = 2'b10;
        w_state_next = S_RWB;
      end
      S_RWB: begin
        RegWrite     = 1'b1;
        instr_done   = 1'b1;
        w_state_next = S_FETCH;
      end
      S_MADDR: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'b10;
        w_state_next = w_is_ldur ? S_MRD : S_MWR;
      end
      S_MRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) w_state_next = S_MWB;
      end
      S_MWB: begin
        RegWrite     = 1'b1;
        MemtoReg     = 1'b1;
        instr_done   = 1'b1;
        w_state_next = S_FETCH;
      end
      S_MWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) w_state_next = S_FETCH;
      end
      S_CBZ: begin
        ALUSrcA      = 1'b1;
        ALUop        = 2'b01;
        PCWriteCond  = 1'b1;
        PCSource     = 1'b1;
        instr_done   = 1'b1;
        w_state_next = S_FETCH;
      end
      S_BR: begin
        PCWrite      = 1'b1;
        PCSource     = 1'b1;
        instr_done   = 1'b1;
        w_state_next = S_FETCH;
      end
      S_ILL: begin
        illegal      = 1'b1;
        instr_done   = 1'b1;
        w_state_next = S_FETCH;
      end
      default: w_state_next = S_START;
    endcase
  end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Multicycle main control FSM for the LEGv8-subset datapath. Sits directly upstream of the ALU control decoder.
- Sequences fetch/decode/execute/memory/writeback for each instruction. Drives ALUop[1:0] and all datapath strobes.
- Handshakes with unified instruction/data memory through mem_ready.
- Maintains a retired-instruction counter.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  11  IR[31:21], stable from DECODE onward.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes current read/write this cycle.
- ALUop  output  2  00 add, 01 pass/compare (CBZ), 10 R-type funct decode.
- ALUSrcA  output  1  0 = PC, 1 = register A.
- ALUSrcB  output  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- PCSource  output  1  0 = ALU result, 1 = ALUOut.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load if zero.
- IorD  output  1  0 = PC address, 1 = ALUOut address.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  load instruction register.
- MemtoReg  output  1  writeback source = MDR.
- RegWrite  output  1  register file write.
- Reg2Loc  output  1  second read port selects IR[4:0].
- instr_done  output  1  one-cycle pulse on final cycle of every instruction.
- illegal  output  1  one-cycle pulse for unsupported opcode.
- instr_count  output  CNT_W  retired instructions, including illegal ones.

Behaviour:
- Asynchronous reset (rst_n low):
  - State is forced to START; instr_count = 0.
  - All strobes are 0. ALUop = 00. Mux selects are 0.
- Outputs:
  - Moore decode of state.
  - PCWrite in FETCH is gated by mem_ready.
  - Reg2Loc = 1 for STUR and CBZ opcodes, 0 otherwise, decoded from opcode.
- Opcode decode:
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - LDUR 11111000010, STUR 11111000000.
  - CBZ: opcode[10:3] = 10110100.
  - B: opcode[10:5] = 000101.
  - Anything else is illegal.
- States, outputs and transitions:
  - START: all strobes 0. Goes to FETCH next cycle.
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=0. IRWrite=1 and PCWrite=1 only when mem_ready. Holds until mem_ready, then goes to DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=00 (branch target into ALUOut). Branches by opcode: R-type to REX, LDUR/STUR to MADDR, CBZ to CBZ, B to BR, else ILL.
  - REX: ALUSrcA=1, ALUSrcB=00, ALUop=10. Goes to RWB.
  - RWB: RegWrite=1, MemtoReg=0, instr_done=1. Goes to FETCH.
  - MADDR: ALUSrcA=1, ALUSrcB=10, ALUop=00. LDUR goes to MRD; STUR goes to MWR.
  - MRD: MemRead=1, IorD=1. Holds until mem_ready, then goes to MWB.
  - MWB: RegWrite=1, MemtoReg=1, instr_done=1. Goes to FETCH.
  - MWR: MemWrite=1, IorD=1. Holds until mem_ready. Asserts instr_done in the mem_ready cycle, then goes to FETCH.
  - CBZ: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=1, instr_done=1. Goes to FETCH.
  - BR: PCWrite=1, PCSource=1, instr_done=1. Goes to FETCH.
  - ILL: illegal=1, instr_done=1, no other strobes. Goes to FETCH; the PC has already advanced by 4.
- Request hold rule: MemRead/MemWrite and IorD stay asserted and stable every cycle until mem_ready. This covers unlimited wait states.
- mem_ready outside FETCH/MRD/MWR is ignored.
- instr_count increments by 1 on every cycle where instr_done=1 and wraps modulo 2^CNT_W.
- Nominal latency with zero wait states: R-type 4, LDUR 5, STUR 4, CBZ 3, B 3, illegal 3 cycles.
- Reset asserted mid-instruction: all strobes drop immediately (asynchronous). No partial RegWrite or MemWrite is issued. Execution resumes START, then FETCH after release.

Test Plan:
- Reset release, mem_ready tied 1, ADD opcode 10001011000 -> states START, FETCH, DECODE, REX (ALUop=10), RWB (RegWrite=1). instr_done pulses once; instr_count=1.
- LDUR with mem_ready low 3 cycles in FETCH and 2 in MRD -> MemRead held stable 4 cycles and 3 cycles respectively. MWB asserts RegWrite=1, MemtoReg=1. Total 10 cycles.
- STUR, mem_ready=1 -> Reg2Loc=1 from DECODE. MWR MemWrite=1, IorD=1 for exactly 1 cycle; RegWrite never asserted.
- CBZ opcode 10110100xxx with zero=1, then zero=0 -> ALUop=01 and PCWriteCond=1 in CBZ state both times. Each instruction takes 3 cycles.
- Opcode 00000000000 -> illegal pulses for 1 cycle in cycle 3, no RegWrite/MemWrite, returns to FETCH. instr_count increments.
- rst_n low during MRD with MemRead high -> MemRead=0 asynchronously, instr_count=0. First post-reset cycle is START with all outputs 0.
